// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and default sizing.
package mul_share_arbiter_pkg;

  localparam int DEF_BITS = 4;
  localparam int DEF_NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester above last_grant, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            any_req_o
);

  // Search order starts one past the previous winner so every requester gets a turn.
  always_comb begin
    int   idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_i) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
      end else begin
        found = found;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/mul_share_arbiter.sv
// One BITS x BITS multiplier shared by NREQ requesters; round-robin grant, one job in flight.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*BITS-1:0]    rsp_product,
  output logic                 busy
);

  localparam int PW = 2 * BITS;

  state_e            state_q, state_d;
  logic [BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_valid_q;
  logic              busy_q;

  logic [NREQ-1:0]   grant_s;
  logic [IDW-1:0]    grant_idx_s;
  logic              any_req_s;
  logic [BITS-1:0]   a_sel_s, b_sel_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant_s),
    .grant_idx_o  (grant_idx_s),
    .any_req_o    (any_req_s)
  );

  // Operand mux for the winning requester.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IDW'(i)) begin
        a_sel_s = req_a[i*BITS +: BITS];
        b_sel_s = req_b[i*BITS +: BITS];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  // Grant must be visible in the same IDLE cycle; masked while reset is applied.
  always_comb begin
    if (rst && (state_q == ST_IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and datapath-load logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    last_d   = last_q;
    prod_d   = prod_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          a_d     = a_sel_s;
          b_d     = b_sel_s;
          id_d    = grant_idx_s;
          last_d  = grant_idx_s;
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        prod_d   = PW'(a_q) * PW'(b_q);
        rsp_id_d = id_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rsp_valid/busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      last_q      <= IDW'(NREQ - 1);
      prod_q      <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = prod_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (BITS=4, NREQ=4).
module tb_mul_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;
  logic        busy;

  int total;
  int bad;

  mul_share_arbiter #(.BITS(4), .NREQ(4), .IDW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  // Starts in IDLE at #1 after an edge; runs grant, MUL, RESP (rsp_ready=1) back to IDLE.
  task automatic run_txn(input string tag, input logic [3:0] valid, input int g, input logic [7:0] p);
    logic [3:0] onehot;
    onehot = 4'd0;
    onehot[g] = 1'b1;
    req_valid = valid;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, {12'd0, req_ready}, {12'd0, onehot});
    tick();
    chk({tag, "_mul_ready"}, {12'd0, req_ready}, 16'd0);
    chk({tag, "_mul_busy"}, {15'd0, busy}, 16'd1);
    chk({tag, "_mul_rv"}, {15'd0, rsp_valid}, 16'd0);
    tick();
    chk({tag, "_rsp_valid"}, {15'd0, rsp_valid}, 16'd1);
    chk({tag, "_rsp_id"}, {14'd0, rsp_id}, 16'(g));
    chk({tag, "_rsp_prod"}, {8'd0, rsp_product}, {8'd0, p});
    chk({tag, "_rsp_ready"}, {12'd0, req_ready}, 16'd0);
    tick();
    chk({tag, "_idle_rv"}, {15'd0, rsp_valid}, 16'd0);
    chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 4'd0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int order [5];
    int fg [5];
    logic [3:0] fv [5];
    total = 0;
    bad = 0;
    rst = 1'b0;
    req_valid = 4'hF;
    req_a = 16'd0;
    req_b = 16'd0;
    rsp_ready = 1'b1;

    // Reset held with every requester valid.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", {12'd0, req_ready}, 16'd0);
      chk("rst_rv", {15'd0, rsp_valid}, 16'd0);
      chk("rst_prod", {8'd0, rsp_product}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_id", {14'd0, rsp_id}, 16'd0);
    end
    rst = 1'b1;
    req_valid = 4'd0;
    tick();
    chk("idle_ready", {12'd0, req_ready}, 16'd0);

    // Single request, max operands.
    set_ops(2, 4'd15, 4'd15);
    run_txn("single", 4'b0100, 2, 8'hE1);
    chk("single_persist", {8'd0, rsp_product}, 16'h00E1);

    // Round-robin with all valid, fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 1), 4'd3);
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      run_txn("rr", 4'hF, order[k], 8'((order[k] + 1) * 3));
    end

    // Backpressure: last grant 0, so requester 1 wins.
    set_ops(1, 4'd7, 4'd9);
    set_ops(3, 4'd2, 4'd3);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", {12'd0, req_ready}, 16'b0010);
    tick();
    req_valid = 4'b1000;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rv", {15'd0, rsp_valid}, 16'd1);
      chk("bp_prod", {8'd0, rsp_product}, 16'd63);
      chk("bp_id", {14'd0, rsp_id}, 16'd1);
      chk("bp_ready", {12'd0, req_ready}, 16'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", {12'd0, req_ready}, 16'd0);
    tick();
    chk("bp_exit_rv", {15'd0, rsp_valid}, 16'd0);
    run_txn("bp_next", 4'b1000, 3, 8'd6);

    // Reset during MUL of requester 1.
    set_ops(1, 4'd5, 4'd5);
    set_ops(0, 4'd3, 4'd4);
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", {12'd0, req_ready}, 16'b0010);
    tick();
    chk("mid_in_mul", {15'd0, busy}, 16'd1);
    rst = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("mid_rst_ready", {12'd0, req_ready}, 16'd0);
    tick();
    chk("mid_busy", {15'd0, busy}, 16'd0);
    chk("mid_prod", {8'd0, rsp_product}, 16'd0);
    tick();
    chk("mid_rv", {15'd0, rsp_valid}, 16'd0);
    rst = 1'b1;
    run_txn("mid_after", 4'b0011, 0, 8'd12);

    // Fairness: requester 3 always valid with zero operand, requester 0 toggling.
    set_ops(3, 4'd0, 4'd9);
    set_ops(0, 4'd6, 4'd7);
    fv = '{4'b1001, 4'b1001, 4'b1000, 4'b1001, 4'b1001};
    fg = '{3, 0, 3, 0, 3};
    for (int k = 0; k < 5; k++) begin
      run_txn("fair", fv[k], fg[k], (fg[k] == 3) ? 8'd0 : 8'd42);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
